// File: rtl/uart_pkg.sv
// +-----------------------------------------------------------------------+
// | uart_pkg : shared UART types, frame constants and parity helper       |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int DATA_BITS   = 8;
  localparam int FRAME_SLOTS = 11;
  localparam int CNT_W       = 16;
  localparam int IDX_W       = $clog2(DATA_BITS);

  // A disabled parity slot still occupies its slot, driven as a mark (1).
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d,
                                     input logic en,
                                     input logic odd);
    return en ? ((^d) ^ odd) : 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_bit_timer.sv
// +-----------------------------------------------------------------------+
// | uart_bit_timer : counts PULSES_BIT clocks per serial slot             |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int PULSES_BIT = 28
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_slot_done
);

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(PULSES_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_slot_done = i_enable && (r_cnt == c_LAST_CNT);

  // Wrapping on slot_done makes every slot boundary restart the count at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_slot_done) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// +-----------------------------------------------------------------------+
// | uart_tx : buffered UART transmitter, start/8 data/parity/stop framing |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int PULSES_BIT = 28,
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready,
  output logic                 data_tx,
  output logic                 busy
);

  uart_state_t          r_state;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_tx;

  logic w_done;
  logic w_idle;
  logic w_accept;
  logic w_load;
  logic w_line;

  assign w_idle   = (r_state == IDLE);
  assign w_accept = valid_in && !r_hold_full;
  assign w_load   = r_hold_full && (w_idle || ((r_state == STOP) && w_done));

  assign ready   = !r_hold_full;
  assign busy    = !w_idle;
  assign data_tx = r_tx;

  uart_bit_timer #(
    .PULSES_BIT (PULSES_BIT)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_idle),
    .i_enable    (!w_idle),
    .o_slot_done (w_done)
  );

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      START:   w_line = 1'b0;
      DATA:    w_line = r_shift[0];
      PARITY:  w_line = r_par;
      default: w_line = 1'b1;
    endcase
  end

  // The line is re-registered from the state so the pin never sees a
  // combinational path; this adds the second clock of handshake latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_idx       <= '0;
      r_tx        <= 1'b1;
    end else begin
      r_tx <= w_line;

      if (w_accept) begin
        r_hold      <= data_in;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        r_shift <= r_hold;
        r_par   <= parity_of(r_hold, PARITY_EN, PARITY_ODD);
      end

      case (r_state)
        IDLE: begin
          if (w_load) r_state <= START;
        end
        START: begin
          if (w_done) begin
            r_state <= DATA;
            r_idx   <= '0;
          end
        end
        DATA: begin
          if (w_done) begin
            r_shift <= r_shift >> 1;
            if (r_idx == IDX_W'(DATA_BITS - 1)) begin
              r_state <= PARITY;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        PARITY: begin
          if (w_done) r_state <= STOP;
        end
        STOP: begin
          if (w_done) r_state <= r_hold_full ? START : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// +-----------------------------------------------------------------------+
// | tb_uart_tx : directed, table-driven bench for uart_tx (3 parity cfgs) |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx;

  localparam int P     = 4;
  localparam int FRAME = 11 * P;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stp;
    logic       glitch;
    int         t;
  } frame_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       pn;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic [2:0] ready;
  logic [2:0] busy;
  logic [2:0] line;

  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;
  int run = 0;
  int last_run = 0;

  frame_t q0[$];
  frame_t q1[$];
  frame_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy[0]) run <= run + 1;
    else if (run != 0) begin
      last_run <= run;
      run      <= 0;
    end
  end

  uart_tx #(.PULSES_BIT(P), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready(ready[0]), .data_tx(line[0]), .busy(busy[0]));

  uart_tx #(.PULSES_BIT(P), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready(ready[1]), .data_tx(line[1]), .busy(busy[1]));

  uart_tx #(.PULSES_BIT(P), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_none (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .ready(ready[2]), .data_tx(line[2]), .busy(busy[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Independent receiver: samples every cycle of each slot, flags any mid-slot change.
  task automatic rx_loop(input int k);
    logic [10:0] v;
    bit          abort;
    bit          glitch;
    int          t0;
    frame_t      f;
    forever begin
      @(negedge clk);
      if (rst_n && line[k] == 1'b0) begin
        v = '1; v[0] = 1'b0; abort = 0; glitch = 0; t0 = cyc;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (!rst_n) abort = 1;
          if (i % P == 0) v[i / P] = line[k];
          else if (line[k] !== v[i / P]) glitch = 1;
        end
        if (!abort) begin
          f.d = v[8:1]; f.par = v[9]; f.stp = v[10]; f.glitch = glitch; f.t = t0;
          case (k)
            0:       q0.push_back(f);
            1:       q1.push_back(f);
            default: q2.push_back(f);
          endcase
        end
      end
    end
  endtask

  function automatic frame_t get(input int k, input int i);
    frame_t f;
    f.d = 'x; f.par = 1'bx; f.stp = 1'bx; f.glitch = 1'bx; f.t = -1000;
    case (k)
      0:       if (i < q0.size()) f = q0[i];
      1:       if (i < q1.size()) f = q1[i];
      default: if (i < q2.size()) f = q2[i];
    endcase
    return f;
  endfunction

  task automatic chk_frame(input string name, input int k, input int i,
                           input logic [7:0] d, input logic p);
    frame_t f;
    f = get(k, i);
    chk(name, {21'd0, f.glitch, f.stp, f.par, f.d}, {21'd0, 1'b0, 1'b1, p, d});
  endtask

  task automatic send(input logic [7:0] b, input bit garble, output int t_hs);
    int n;
    n = 0;
    @(negedge clk);
    valid_in = 1'b1;
    data_in  = b;
    while (!ready[0] && n < 1000) begin
      if (garble) data_in = 8'($urandom);
      @(negedge clk);
      n++;
    end
    data_in = b;
    if (n >= 1000) begin
      n_tot++;
      $display("FAIL send_timeout: byte 0x%0h never accepted, ready=%b", b, ready);
    end
    @(posedge clk);
    #1;
    t_hs = cyc;
  endtask

  task automatic drop();
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy != 3'b000 || ready != 3'b111) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      n_tot++;
      $display("FAIL idle_timeout: busy=%b ready=%b", busy, ready);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t       vt[6];
    int         base, base1, base2, t, t2, bad, errs;
    logic [7:0] lb[256];
    frame_t     f;
    logic       p;

    vt[0] = '{8'hA5, 1'b0, 1'b1, 1'b1};
    vt[1] = '{8'h01, 1'b1, 1'b0, 1'b1};
    vt[2] = '{8'h80, 1'b1, 1'b0, 1'b1};
    vt[3] = '{8'h00, 1'b0, 1'b1, 1'b1};
    vt[4] = '{8'hFF, 1'b0, 1'b1, 1'b1};
    vt[5] = '{8'h13, 1'b1, 1'b0, 1'b1};

    fork
      rx_loop(0);
      rx_loop(1);
      rx_loop(2);
    join_none

    #1 rst_n = 1'b0;
    #1 chk("reset_state", {23'd0, line, ready, busy}, {23'd0, 3'b111, 3'b111, 3'b000});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (line !== 3'b111 || ready !== 3'b111 || busy !== 3'b000) bad++;
    end
    chk("idle_50", bad, 0);

    // Single 0xA5 frame: latency, bit pattern, busy duration
    base = q0.size();
    send(8'hA5, 1'b0, t);
    drop();
    wait_idle();
    chk_frame("a5_frame", 0, base, 8'hA5, 1'b0);
    chk("a5_latency", get(0, base).t - t, 2);
    chk("a5_busy_len", last_run, FRAME);

    // Back-to-back with valid held
    base = q0.size();
    send(8'h01, 1'b0, t);
    chk("b2b_ready_drop", {31'd0, ready[0]}, 0);
    send(8'h80, 1'b0, t2);
    chk("b2b_second_held", {31'd0, ready[0]}, 0);
    chk("b2b_accept_gap", t2 - t, 2);
    drop();
    wait_idle();
    chk_frame("b2b_frame1", 0, base, 8'h01, 1'b1);
    chk_frame("b2b_frame2", 0, base + 1, 8'h80, 1'b1);
    chk("b2b_period", get(0, base + 1).t - get(0, base).t, FRAME);

    // Table vectors across even / odd / disabled parity
    base = q0.size(); base1 = q1.size(); base2 = q2.size();
    for (int i = 0; i < 6; i++) send(vt[i].d, 1'b0, t);
    drop();
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      chk_frame($sformatf("vec%0d_even", i), 0, base + i, vt[i].d, vt[i].pe);
      chk_frame($sformatf("vec%0d_odd", i), 1, base1 + i, vt[i].d, vt[i].po);
      chk_frame($sformatf("vec%0d_nopar", i), 2, base2 + i, vt[i].d, vt[i].pn);
    end

    // data_in churns while ready=0; only accepted bytes may appear
    base = q0.size();
    send(8'h11, 1'b1, t);
    send(8'h22, 1'b1, t);
    send(8'h07, 1'b1, t);
    drop();
    wait_idle();
    chk("hold_count", q0.size() - base, 3);
    chk_frame("hold_b0", 0, base, 8'h11, 1'b0);
    chk_frame("hold_b1", 0, base + 1, 8'h22, 1'b0);
    chk_frame("hold_b2", 0, base + 2, 8'h07, 1'b1);

    // Asynchronous reset in D1 of 0x3C with 0x99 held
    base = q0.size(); base1 = q1.size(); base2 = q2.size();
    send(8'h3C, 1'b0, t);
    send(8'h99, 1'b0, t2);
    drop();
    repeat (9) @(negedge clk);
    chk("pre_reset", {23'd0, line, ready, busy}, {23'd0, 3'b000, 3'b000, 3'b111});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {23'd0, line, ready, busy}, {23'd0, 3'b111, 3'b111, 3'b000});
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (line !== 3'b111 || ready !== 3'b111 || busy !== 3'b000) bad++;
    end
    chk("post_reset_idle", bad, 0);
    chk("post_reset_frames", (q0.size() - base) + (q1.size() - base1) + (q2.size() - base2), 0);

    // Loopback: 256 random bytes in order
    base = q0.size(); base1 = q1.size();
    for (int i = 0; i < 256; i++) begin
      lb[i] = 8'($urandom);
      send(lb[i], 1'b0, t);
    end
    drop();
    wait_idle();
    chk("loop_count", q0.size() - base, 256);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      f = get(0, base + i);
      p = ^lb[i];
      if (f.d !== lb[i] || f.par !== p || f.stp !== 1'b1 || f.glitch !== 1'b0) errs++;
      f = get(1, base1 + i);
      if (f.d !== lb[i] || f.par !== ~p) errs++;
    end
    chk("loop_errors", errs, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
